// File: rtl/cmd_addr_sequencer.sv
// Issues a NAND bus preamble (CMD1, 0..5 address bytes, optional CMD2) to the
// command/address latch units through an activate/busy handshake per item.
module cmd_addr_sequencer #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start,
  input  logic [7:0]  cmd1,
  input  logic [39:0] addr,
  input  logic [2:0]  addr_count,
  input  logic        cmd2_en,
  input  logic [7:0]  cmd2,
  output logic        cle_activate,
  output logic        ale_activate,
  output logic [15:0] latch_data,
  input  logic        cle_busy,
  input  logic        ale_busy,
  output logic        seq_busy,
  output logic        done,
  output logic        error
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_GAP     = 3'd4,
    ST_FINISH  = 3'd5
  } state_t;

  state_t             state_r;
  logic [7:0]         cmd1_r;
  logic [39:0]        addr_r;
  logic               cmd2_en_r;
  logic [7:0]         cmd2_r;
  logic [2:0]         last_idx_r;
  logic [2:0]         idx_r;
  logic               sel_ale_r;
  logic [TMO_W-1:0]   tmo_cnt_r;
  logic [GAP_W-1:0]   gap_cnt_r;
  logic               cle_act_r;
  logic               ale_act_r;
  logic [15:0]        latch_data_r;
  logic               seq_busy_r;
  logic               done_r;
  logic               error_r;

  logic [2:0]         count_clamped_s;
  logic [2:0]         load_idx_s;
  logic               item_is_ale_s;
  logic [7:0]         item_byte_s;
  logic               sel_busy_s;

  function automatic logic [7:0] addr_byte(input logic [39:0] a, input logic [2:0] n);
    logic [7:0] b;
    case (n)
      3'd0:    b = a[7:0];
      3'd1:    b = a[15:8];
      3'd2:    b = a[23:16];
      3'd3:    b = a[31:24];
      3'd4:    b = a[39:32];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Item decode: index 0 is CMD1, the final index is CMD2 when enabled, the rest are address bytes
  always_comb begin
    count_clamped_s = addr_count;
    load_idx_s      = idx_r;
    item_is_ale_s   = 1'b0;
    item_byte_s     = 8'h00;
    sel_busy_s      = 1'b0;
    if (addr_count > 3'd5) begin
      count_clamped_s = 3'd5;
    end else begin
      count_clamped_s = addr_count;
    end
    // idx_r is already advanced on entry to GAP; the zero-gap path loads straight from WAIT_LO
    if (state_r == ST_GAP) begin
      load_idx_s = idx_r;
    end else begin
      load_idx_s = idx_r + 3'd1;
    end
    if (load_idx_s == 3'd0) begin
      item_is_ale_s = 1'b0;
      item_byte_s   = cmd1_r;
    end else if (cmd2_en_r && (load_idx_s == last_idx_r)) begin
      item_is_ale_s = 1'b0;
      item_byte_s   = cmd2_r;
    end else begin
      item_is_ale_s = 1'b1;
      item_byte_s   = addr_byte(addr_r, load_idx_s - 3'd1);
    end
    if (sel_ale_r) begin
      sel_busy_s = ale_busy;
    end else begin
      sel_busy_s = cle_busy;
    end
  end

  // Sequencer FSM, captured request and registered outputs
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r      <= ST_IDLE;
      cmd1_r       <= 8'h00;
      addr_r       <= 40'h00_0000_0000;
      cmd2_en_r    <= 1'b0;
      cmd2_r       <= 8'h00;
      last_idx_r   <= 3'd0;
      idx_r        <= 3'd0;
      sel_ale_r    <= 1'b0;
      tmo_cnt_r    <= {TMO_W{1'b0}};
      gap_cnt_r    <= {GAP_W{1'b0}};
      cle_act_r    <= 1'b0;
      ale_act_r    <= 1'b0;
      latch_data_r <= 16'h0000;
      seq_busy_r   <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      cle_act_r <= 1'b0;
      ale_act_r <= 1'b0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            cmd1_r       <= cmd1;
            addr_r       <= addr;
            cmd2_en_r    <= cmd2_en;
            cmd2_r       <= cmd2;
            last_idx_r   <= count_clamped_s + {2'b00, cmd2_en};
            idx_r        <= 3'd0;
            sel_ale_r    <= 1'b0;
            latch_data_r <= {8'h00, cmd1};
            seq_busy_r   <= 1'b1;
            state_r      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cle_act_r <= ~sel_ale_r;
          ale_act_r <= sel_ale_r;
          tmo_cnt_r <= {TMO_W{1'b0}};
          state_r   <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (sel_busy_s) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
            state_r   <= ST_WAIT_LO;
          end else if (tmo_cnt_r == TMO_LAST) begin
            error_r      <= 1'b1;
            latch_data_r <= 16'h0000;
            seq_busy_r   <= 1'b0;
            state_r      <= ST_IDLE;
          end else if (tmo_cnt_r != TMO_MAX) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
          end
        end
        ST_WAIT_LO: begin
          if (!sel_busy_s) begin
            if (idx_r == last_idx_r) begin
              latch_data_r <= 16'h0000;
              state_r      <= ST_FINISH;
            end else if (GAP_CYCLES == 0) begin
              idx_r        <= load_idx_s;
              sel_ale_r    <= item_is_ale_s;
              latch_data_r <= {8'h00, item_byte_s};
              state_r      <= ST_ISSUE;
            end else begin
              idx_r        <= load_idx_s;
              latch_data_r <= 16'h0000;
              gap_cnt_r    <= {GAP_W{1'b0}};
              state_r      <= ST_GAP;
            end
          end else if (tmo_cnt_r == TMO_LAST) begin
            error_r      <= 1'b1;
            latch_data_r <= 16'h0000;
            seq_busy_r   <= 1'b0;
            state_r      <= ST_IDLE;
          end else if (tmo_cnt_r != TMO_MAX) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            sel_ale_r    <= item_is_ale_s;
            latch_data_r <= {8'h00, item_byte_s};
            state_r      <= ST_ISSUE;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_ONE;
          end
        end
        ST_FINISH: begin
          done_r     <= 1'b1;
          seq_busy_r <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          latch_data_r <= 16'h0000;
          seq_busy_r   <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign cle_activate = cle_act_r;
  assign ale_activate = ale_act_r;
  assign latch_data   = latch_data_r;
  assign seq_busy     = seq_busy_r;
  assign done         = done_r;
  assign error        = error_r;

endmodule

// File: tb/tb_cmd_addr_sequencer.sv
// Scoreboard bench for cmd_addr_sequencer: two instances (gap 3 and gap 0),
// simple registered-busy latch models, and per-scenario check tasks.
module tb_cmd_addr_sequencer;

  logic              clk = 1'b0;
  logic              nreset;
  logic [1:0]        start_v;
  logic [7:0]        cmd1, cmd2;
  logic [39:0]       addr;
  logic [2:0]        addr_count;
  logic              cmd2_en;
  logic [1:0]        cle_act, ale_act, cle_busy, ale_busy, seq_busy, done, error;
  logic [1:0][15:0]  latch_data;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_cle    = 0;
  int n_ale    = 0;
  int n_done   = 0;
  int n_err    = 0;
  int act_cyc  = 0;
  int err_cyc  = 0;
  logic        stuck = 1'b0;
  logic [15:0] last_data = 16'h0000;
  logic [8:0]  exp_q[$];

  always #5 clk = ~clk;

  cmd_addr_sequencer #(.GAP_CYCLES(3), .TIMEOUT_CYCLES(16)) u_dut (
    .clk(clk), .nreset(nreset), .start(start_v[0]), .cmd1(cmd1), .addr(addr),
    .addr_count(addr_count), .cmd2_en(cmd2_en), .cmd2(cmd2),
    .cle_activate(cle_act[0]), .ale_activate(ale_act[0]), .latch_data(latch_data[0]),
    .cle_busy(cle_busy[0]), .ale_busy(ale_busy[0]), .seq_busy(seq_busy[0]),
    .done(done[0]), .error(error[0])
  );

  cmd_addr_sequencer #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(16)) u_dut_g0 (
    .clk(clk), .nreset(nreset), .start(start_v[1]), .cmd1(cmd1), .addr(addr),
    .addr_count(addr_count), .cmd2_en(cmd2_en), .cmd2(cmd2),
    .cle_activate(cle_act[1]), .ale_activate(ale_act[1]), .latch_data(latch_data[1]),
    .cle_busy(cle_busy[1]), .ale_busy(ale_busy[1]), .seq_busy(seq_busy[1]),
    .done(done[1]), .error(error[1])
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Latch unit models: busy rises two clocks after activate, stays high four clocks
  logic [1:0] c_pend, a_pend;
  logic [2:0] c_hold [2];
  logic [2:0] a_hold [2];
  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      c_pend <= 2'b00; a_pend <= 2'b00; cle_busy <= 2'b00; ale_busy <= 2'b00;
      for (int g = 0; g < 2; g++) begin c_hold[g] <= 3'd0; a_hold[g] <= 3'd0; end
    end else begin
      for (int g = 0; g < 2; g++) begin
        c_pend[g] <= cle_act[g] && !(stuck && (g == 0));
        a_pend[g] <= ale_act[g];
        if (c_pend[g]) begin cle_busy[g] <= 1'b1; c_hold[g] <= 3'd3; end
        else if (c_hold[g] != 3'd0) c_hold[g] <= c_hold[g] - 3'd1;
        else cle_busy[g] <= 1'b0;
        if (a_pend[g]) begin ale_busy[g] <= 1'b1; a_hold[g] <= 3'd3; end
        else if (a_hold[g] != 3'd0) a_hold[g] <= a_hold[g] - 3'd1;
        else ale_busy[g] <= 1'b0;
      end
    end
  end

  // Scoreboard monitor for the gap-3 instance
  always @(negedge clk) begin
    logic [8:0] exp_item;
    if (nreset) begin
      if (cle_act[0] || ale_act[0]) begin
        n_checks++;
        if (cle_act[0] && ale_act[0]) $display("FAIL both_activates got cle=1 ale=1 want one");
        else if (exp_q.size() == 0) $display("FAIL unexpected_item got ale=%0b data=%h want none", ale_act[0], latch_data[0]);
        else begin
          exp_item = exp_q.pop_front();
          if ({ale_act[0], latch_data[0]} !== {exp_item[8], 8'h00, exp_item[7:0]})
            $display("FAIL item got ale=%0b data=%h want ale=%0b data=%h", ale_act[0], latch_data[0], exp_item[8], {8'h00, exp_item[7:0]});
          else n_pass++;
        end
        n_checks++;
        if ((cle_act[0] && cle_busy[0]) || (ale_act[0] && ale_busy[0])) $display("FAIL activate_while_busy got busy=1 want 0");
        else n_pass++;
        if (cle_act[0]) n_cle++;
        if (ale_act[0]) n_ale++;
        act_cyc   = cyc;
        last_data = latch_data[0];
      end else if (cle_busy[0] || ale_busy[0]) begin
        n_checks++;
        if (latch_data[0] !== last_data) $display("FAIL data_stable got %h want %h", latch_data[0], last_data);
        else n_pass++;
      end
      if (done[0]) n_done++;
      if (error[0]) begin n_err++; err_cyc = cyc; end
    end
  end

  task automatic clear_counts();
    n_cle = 0; n_ale = 0; n_done = 0; n_err = 0;
  endtask

  task automatic run(input int g, input logic [7:0] c1, input logic [39:0] a, input logic [2:0] cnt,
                     input logic c2en, input logic [7:0] c2, input logic hold);
    int n;
    cmd1 = c1; addr = a; addr_count = cnt; cmd2_en = c2en; cmd2 = c2;
    start_v[g] = 1'b1;
    if (g == 0) begin
      n = (cnt > 3'd5) ? 5 : int'(cnt);
      exp_q.push_back({1'b0, c1});
      for (int i = 0; i < n; i++) exp_q.push_back({1'b1, a[8*i +: 8]});
      if (c2en) exp_q.push_back({1'b0, c2});
    end
    @(negedge clk);
    start_v[g] = hold;
    cmd1 = ~c1; addr = ~a; addr_count = 3'd0; cmd2_en = ~c2en; cmd2 = ~c2;
  endtask

  task automatic wait_end(input int g, input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done[g] || error[g]) seen = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    nreset = 1'b0; start_v = 2'b00; cmd1 = 8'h00; cmd2 = 8'h00; addr = 40'h0; addr_count = 3'd0; cmd2_en = 1'b0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      n_checks++;
      if ({cle_act[g], ale_act[g], seq_busy[g], done[g], error[g], latch_data[g]} !== 21'h0)
        $display("FAIL reset_outputs dut%0d got %h want 0", g, {cle_act[g], ale_act[g], seq_busy[g], done[g], error[g], latch_data[g]});
      else n_pass++;
    end
    nreset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_preamble();
    logic seen;
    clear_counts();
    run(0, 8'h00, 40'h04_0302_0100, 3'd5, 1'b1, 8'h30, 1'b0);
    wait_end(0, 400, seen);
    n_checks++; if (!seen) $display("FAIL read_end got timeout want done"); else n_pass++;
    n_checks++; if (n_done !== 1 || n_err !== 0) $display("FAIL read_done got done=%0d err=%0d want 1/0", n_done, n_err); else n_pass++;
    n_checks++; if (n_cle !== 2 || n_ale !== 5) $display("FAIL read_counts got cle=%0d ale=%0d want 2/5", n_cle, n_ale); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL read_queue got %0d left want 0", exp_q.size()); else n_pass++;
    n_checks++; if (seq_busy[0] !== 1'b0 || latch_data[0] !== 16'h0000) $display("FAIL read_idle got busy=%0b data=%h want 0/0000", seq_busy[0], latch_data[0]); else n_pass++;
  endtask

  task automatic test_reset_cmd();
    logic seen;
    clear_counts();
    run(0, 8'hFF, 40'h0, 3'd0, 1'b0, 8'h00, 1'b0);
    wait_end(0, 200, seen);
    n_checks++; if (!seen || n_done !== 1) $display("FAIL rstcmd_done got %0d want 1", n_done); else n_pass++;
    n_checks++; if (n_cle !== 1 || n_ale !== 0) $display("FAIL rstcmd_counts got cle=%0d ale=%0d want 1/0", n_cle, n_ale); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL rstcmd_queue got %0d left want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_timeout();
    logic seen;
    clear_counts();
    stuck = 1'b1;
    run(0, 8'h70, 40'h0, 3'd0, 1'b0, 8'h00, 1'b0);
    wait_end(0, 100, seen);
    n_checks++; if (!seen || n_err !== 1) $display("FAIL tmo_error got %0d want 1", n_err); else n_pass++;
    n_checks++; if (err_cyc - act_cyc !== 16) $display("FAIL tmo_latency got %0d want 16", err_cyc - act_cyc); else n_pass++;
    repeat (10) @(negedge clk);
    #1;
    n_checks++; if (n_done !== 0) $display("FAIL tmo_no_done got %0d want 0", n_done); else n_pass++;
    n_checks++; if (n_cle !== 1 || n_ale !== 0 || seq_busy[0] !== 1'b0) $display("FAIL tmo_quiet got cle=%0d ale=%0d busy=%0b want 1/0/0", n_cle, n_ale, seq_busy[0]); else n_pass++;
    stuck = 1'b0;
  endtask

  task automatic test_spacing(input int g, input int gap);
    int   phase, fall, delta;
    logic [15:0] data;
    logic seen;
    clear_counts();
    phase = 0; fall = 0; delta = -1; data = 16'h0000;
    run(g, 8'h80, 40'h00_0000_00A5, 3'd1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 200 && phase < 3; i++) begin
      @(negedge clk);
      case (phase)
        0: if (cle_busy[g]) phase = 1;
        1: if (!cle_busy[g]) begin fall = cyc; phase = 2; end
        2: if (ale_act[g]) begin delta = cyc - fall; data = latch_data[g]; phase = 3; end
        default: ;
      endcase
    end
    // low level is sampled on the edge after it is first seen; activate follows gap+1 clocks later
    n_checks++; if (delta !== gap + 2) $display("FAIL spacing_gap%0d got %0d want %0d", gap, delta, gap + 2); else n_pass++;
    n_checks++; if (data !== 16'h00A5) $display("FAIL spacing_data_gap%0d got %h want 00a5", gap, data); else n_pass++;
    wait_end(g, 200, seen);
    n_checks++; if (!seen || done[g] !== 1'b1) $display("FAIL spacing_done_gap%0d got %0b want 1", gap, done[g]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic seen;
    clear_counts();
    run(0, 8'h00, 40'h0A_0B0C_0D0E, 3'd5, 1'b1, 8'h30, 1'b0);
    for (int i = 0; i < 200 && n_ale < 2; i++) @(negedge clk);
    #2 nreset = 1'b0;
    #1;
    n_checks++;
    if ({cle_act[0], ale_act[0], seq_busy[0], done[0], error[0], latch_data[0]} !== 21'h0)
      $display("FAIL midreset_outputs got %h want 0", {cle_act[0], ale_act[0], seq_busy[0], done[0], error[0], latch_data[0]});
    else n_pass++;
    exp_q.delete();
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    clear_counts();
    run(0, 8'h00, 40'h04_0302_0100, 3'd5, 1'b1, 8'h30, 1'b0);
    wait_end(0, 400, seen);
    n_checks++; if (!seen || n_done !== 1) $display("FAIL midreset_done got %0d want 1", n_done); else n_pass++;
    n_checks++; if (n_cle !== 2 || n_ale !== 5) $display("FAIL midreset_counts got cle=%0d ale=%0d want 2/5", n_cle, n_ale); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL midreset_queue got %0d left want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_start_held();
    logic seen;
    clear_counts();
    seen = 1'b0;
    run(0, 8'h05, 40'h11_2233_4455, 3'd7, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done[0] || error[0]) seen = 1'b1;
    end
    start_v[0] = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    n_checks++; if (!seen || n_done !== 1) $display("FAIL held_done got %0d want 1", n_done); else n_pass++;
    n_checks++; if (n_cle !== 1 || n_ale !== 5) $display("FAIL held_counts got cle=%0d ale=%0d want 1/5", n_cle, n_ale); else n_pass++;
    n_checks++; if (exp_q.size() !== 0 || seq_busy[0] !== 1'b0) $display("FAIL held_idle got q=%0d busy=%0b want 0/0", exp_q.size(), seq_busy[0]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic seen;
    clear_counts();
    seen = 1'b0;
    run(0, 8'h01, 40'h00_0000_0077, 3'd1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done[0]) seen = 1'b1;
    end
    n_checks++; if (!seen) $display("FAIL b2b_first got timeout want done"); else n_pass++;
    run(0, 8'h02, 40'h00_0000_EE99, 3'd2, 1'b1, 8'h10, 1'b0);
    wait_end(0, 400, seen);
    n_checks++; if (!seen || n_done !== 2) $display("FAIL b2b_done got %0d want 2", n_done); else n_pass++;
    n_checks++; if (n_cle !== 3 || n_ale !== 3 || exp_q.size() !== 0) $display("FAIL b2b_counts got cle=%0d ale=%0d q=%0d want 3/3/0", n_cle, n_ale, exp_q.size()); else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_read_preamble();
    test_reset_cmd();
    test_timeout();
    test_spacing(0, 3);
    test_spacing(1, 0);
    test_reset_mid();
    test_start_held();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
